// File: rtl/configurable_demux_reg_if.sv
// configurable_demux_reg_if: write-side bus and registered entry table of the demux register bank.
interface configurable_demux_reg_if #(
    parameter int nb_bits_select        = 5,
    parameter int nb_bits_taille_donnes = 32
);
    logic                                                           we_i;
    logic [nb_bits_select-1:0]                                      sel_i;
    logic [nb_bits_taille_donnes-1:0]                               data_i;
    logic                                                           clear_i;
    logic [2**nb_bits_select-1:0][nb_bits_taille_donnes-1:0]        data_o;
    logic [2**nb_bits_select-1:0]                                   valid_o;
    logic [15:0]                                                    wr_count_o;
    logic                                                           wr_ack_o;
    modport master (output we_i, sel_i, data_i, clear_i, input data_o, valid_o, wr_count_o, wr_ack_o);
    modport slave  (input we_i, sel_i, data_i, clear_i, output data_o, valid_o, wr_count_o, wr_ack_o);
endinterface

// File: rtl/configurable_demux_reg.sv
// configurable_demux_reg: steers one word per cycle into a registered entry table, with
// optional hardwired-zero entry 0, per-entry valid flags, saturating write count and write ack.
module configurable_demux_reg #(
    parameter int nb_bits_select        = 5,
    parameter int nb_bits_taille_donnes = 32,
    parameter int zero_entry            = 1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    configurable_demux_reg_if.slave bus
);
    localparam int n = 2**nb_bits_select;
    logic [n-1:0][nb_bits_taille_donnes-1:0] data_q, data_d;
    logic [n-1:0]                            valid_q, valid_d;
    logic [15:0]                             cnt_q, cnt_d;
    logic                                    ack_q, ack_d;
    logic                                    accept;
    // we_i gates first so X on sel_i/data_i while idle cannot reach state
    assign accept = bus.we_i && !bus.clear_i && !((zero_entry != 0) && (bus.sel_i == '0));
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (accept) begin
            data_d[bus.sel_i]  = bus.data_i;
            valid_d[bus.sel_i] = 1'b1;
        end
        cnt_d = (accept && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        ack_d = accept;
        if (bus.clear_i) begin
            data_d  = '0;
            valid_d = '0;
            cnt_d   = '0;
            ack_d   = 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end
    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.wr_count_o = cnt_q;
    assign bus.wr_ack_o   = ack_q;
endmodule

// File: tb/tb_configurable_demux_reg.sv
// tb_configurable_demux_reg: drives a zero-entry and a plain instance in lockstep and checks
// both against an array model of the entry table, flags, count and ack.
module tb_configurable_demux_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    configurable_demux_reg_if #(.nb_bits_select(5), .nb_bits_taille_donnes(32)) bz ();
    configurable_demux_reg_if #(.nb_bits_select(5), .nb_bits_taille_donnes(32)) bn ();

    configurable_demux_reg #(.nb_bits_select(5), .nb_bits_taille_donnes(32), .zero_entry(1)) dut_z (
        .clk_i(clk), .rst_i(rst), .bus(bz));
    configurable_demux_reg #(.nb_bits_select(5), .nb_bits_taille_donnes(32), .zero_entry(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .bus(bn));

    // model index 0 tracks dut_z, index 1 tracks dut_n
    logic [31:0] m_data [2][32];
    logic [31:0] m_valid [2];
    int          m_cnt [2];
    logic        m_ack [2];
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int k, input logic [1023:0] d,
                             input logic [31:0] v, input logic [15:0] c, input logic a);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s.data[%0d]", nm, i), 64'(d[i*32 +: 32]), 64'(m_data[k][i]));
        chk({nm, ".valid"}, 64'(v), 64'(m_valid[k]));
        chk({nm, ".count"}, 64'(c), 64'(m_cnt[k]));
        chk({nm, ".ack"}, 64'(a), 64'(m_ack[k]));
    endtask

    task automatic check_all(input string ph);
        check_dut({ph, ".z"}, 0, bz.data_o, bz.valid_o, bz.wr_count_o, bz.wr_ack_o);
        check_dut({ph, ".n"}, 1, bn.data_o, bn.valid_o, bn.wr_count_o, bn.wr_ack_o);
    endtask

    task automatic model_step(input logic we, input logic [4:0] sel, input logic [31:0] data,
                              input logic clr, input logic r);
        for (int k = 0; k < 2; k++) begin
            if (r || clr) begin
                for (int i = 0; i < 32; i++) m_data[k][i] = '0;
                m_valid[k] = '0;
                m_cnt[k]   = 0;
                m_ack[k]   = 1'b0;
            end else if (we === 1'b1 && !(k == 0 && sel == 5'd0)) begin
                m_data[k][sel]  = data;
                m_valid[k][sel] = 1'b1;
                m_cnt[k]        = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
                m_ack[k]        = 1'b1;
            end else begin
                m_ack[k] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic we, input logic [4:0] sel, input logic [31:0] data,
                         input logic clr, input logic r, input bit do_chk = 1'b1);
        rst = r;
        bz.we_i = we;  bz.sel_i = sel;  bz.data_i = data;  bz.clear_i = clr;
        bn.we_i = we;  bn.sel_i = sel;  bn.data_i = data;  bn.clear_i = clr;
        if (do_chk) begin
            #2;
            check_all("pre");
        end
        @(posedge clk);
        model_step(we, sel, data, clr, r);
        #1;
        if (do_chk) check_all("post");
    endtask

    initial begin
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("reset.valid", 64'(bz.valid_o), 64'd0);
        chk("reset.count", 64'(bz.wr_count_o), 64'd0);
        chk("reset.ack", 64'(bz.wr_ack_o), 64'd0);

        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("wr.data5", 64'(bz.data_o[5]), 64'hDEADBEEF);
        chk("wr.valid", 64'(bz.valid_o), 64'h20);
        chk("wr.count", 64'(bz.wr_count_o), 64'd1);
        chk("wr.ack", 64'(bz.wr_ack_o), 64'd1);
        cycle(1'b0, 5'bx, 32'bx, 1'b0, 1'b0);
        chk("idle.ack", 64'(bz.wr_ack_o), 64'd0);
        chk("idle.data5", 64'(bz.data_o[5]), 64'hDEADBEEF);

        cycle(1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0);
        chk("zero.z.data0", 64'(bz.data_o[0]), 64'd0);
        chk("zero.z.valid0", 64'(bz.valid_o[0]), 64'd0);
        chk("zero.z.count", 64'(bz.wr_count_o), 64'd1);
        chk("zero.z.ack", 64'(bz.wr_ack_o), 64'd0);
        chk("zero.n.data0", 64'(bn.data_o[0]), 64'h12345678);
        chk("zero.n.count", 64'(bn.wr_count_o), 64'd2);

        cycle(1'b1, 5'd3, 32'h33333333, 1'b0, 1'b0);
        cycle(1'b1, 5'd7, 32'h77777777, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'hCCCCCCCC, 1'b1, 1'b0);
        chk("clr.data3", 64'(bz.data_o[3]), 64'd0);
        chk("clr.data7", 64'(bz.data_o[7]), 64'd0);
        chk("clr.valid", 64'(bz.valid_o), 64'd0);
        chk("clr.count", 64'(bz.wr_count_o), 64'd0);
        cycle(1'b1, 5'd3, 32'h33333333, 1'b0, 1'b0);
        cycle(1'b1, 5'd4, 32'h44444444, 1'b1, 1'b1);
        chk("rstclr.valid", 64'(bn.valid_o), 64'd0);
        chk("rstclr.count", 64'(bn.wr_count_o), 64'd0);

        cycle(1'b1, 5'd9, 32'h1, 1'b0, 1'b0);
        chk("b2b.ack1", 64'(bz.wr_ack_o), 64'd1);
        cycle(1'b1, 5'd9, 32'h2, 1'b0, 1'b0);
        chk("b2b.ack2", 64'(bz.wr_ack_o), 64'd1);
        chk("b2b.data9", 64'(bz.data_o[9]), 64'h2);
        chk("b2b.count", 64'(bz.wr_count_o), 64'd2);
        cycle(1'b0, 5'd9, 32'h3, 1'b0, 1'b0);
        chk("b2b.ack3", 64'(bz.wr_ack_o), 64'd0);

        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
        chk("sweep.z.valid", 64'(bz.valid_o), 64'hFFFFFFFE);
        chk("sweep.n.valid", 64'(bn.valid_o), 64'hFFFFFFFE);
        chk("sweep.data17", 64'(bz.data_o[17]), 64'd17);
        chk("sweep.count", 64'(bz.wr_count_o), 64'd31);

        repeat (300)
            cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);

        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        repeat (65537) cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 1'b0, 1'b0);
        check_all("sat");
        chk("sat.count", 64'(bz.wr_count_o), 64'hFFFF);
        cycle(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 1'b0);
        chk("sat.data12", 64'(bz.data_o[12]), 64'hCAFEF00D);
        chk("sat.count2", 64'(bz.wr_count_o), 64'hFFFF);
        chk("sat.ack", 64'(bz.wr_ack_o), 64'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/configurable_demux_reg.md
# configurable_demux_reg

Registered demultiplexer: the write-side counterpart of the team's configurable read multiplexer. A single data word is steered by a select index into one of 2**nb_bits_select storage entries on a clock edge. The full entry table is presented as a packed array, shaped to feed the multiplexer's `data_i` directly. The intended first use is the write port of the RV32I register bank: 5-bit select, 32-bit data, entry 0 hardwired to zero.

## Interface
- nb_bits_select, default 5: select width; the bank has 2**nb_bits_select entries.
- nb_bits_taille_donnes, default 32: data width per entry.
- zero_entry, default 1: when 1, entry 0 is read-only zero and writes to it are discarded.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- we_i  in  1  write enable for the current cycle.
- sel_i  in  nb_bits_select  destination entry index.
- data_i  in  nb_bits_taille_donnes  word to write.
- clear_i  in  1  synchronous clear of all entries, valid flags and counter.
- data_o  out  [2**nb_bits_select-1:0][nb_bits_taille_donnes-1:0]  registered entry table.
- valid_o  out  2**nb_bits_select  per-entry flag: entry written since last reset/clear.
- wr_count_o  out  16  count of accepted writes, saturating.
- wr_ack_o  out  1  one-cycle pulse; asserted the cycle after an accepted write.

## Operation
- Accepted write: we_i=1, rst_i=0, clear_i=0, and not (zero_entry=1 and sel_i=0).
- On an accepted write at edge t:
  - data_o[sel_i] <= data_i;
  - valid_o[sel_i] <= 1;
  - wr_count_o increments, saturating at 16'hFFFF;
  - wr_ack_o <= 1 for exactly one cycle.
- All entries not selected hold their value; only one entry changes per cycle.
- Rejected write (we_i=1 to entry 0 with zero_entry=1):
  - data_o[0] stays 0 and valid_o[0] stays 0;
  - counter unchanged; wr_ack_o=0.
- we_i=0: no state change; wr_ack_o=0 next cycle.
- Priority when events coincide: rst_i > clear_i > write.
  - clear_i together with we_i: the write is dropped, and all state clears.
- clear_i has the same effect as reset on all outputs; it is a separate port for pipeline flush use.
- sel_i and data_i are ignored when we_i=0; X on them must not propagate into state.
- zero_entry=0: entry 0 behaves like any other entry.

## Timing
- Reset values (rst_i=1 at an edge): data_o all zero, valid_o all zero, wr_count_o=0, wr_ack_o=0.
- Reset mid-operation: a write presented in the reset cycle is lost; state is all-zero on the next cycle.
- Write latency is 1 cycle. Data written at edge t appears on data_o after edge t, so it is readable through the mux in cycle t+1.
- No write-to-read bypass: during the write cycle, data_o[sel_i] still shows the old value.
- Back-to-back writes to the same entry on consecutive cycles: the last one wins; each write counts and each produces a wr_ack_o pulse.
  - wr_ack_o then stays high across consecutive cycles, one cycle per write.
- Counter saturation: at 16'hFFFF, further accepted writes still update data/valid and still pulse wr_ack_o; the count stays at 16'hFFFF.
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset with prior garbage: run rst_i=1 for 2 cycles -> data_o all 0, valid_o=0, wr_count_o=0, wr_ack_o=0.
- Write, then read back:
  - stimulus: write sel_i=5, data_i=32'hDEADBEEF at t;
  - at t+1: data_o[5]=32'hDEADBEEF, valid_o=32'h20, wr_count_o=1, wr_ack_o=1;
  - at t+2: wr_ack_o=0;
  - in cycle t: data_o[5] is still 0.
- Zero-entry protection (zero_entry=1): write sel_i=0, data_i=32'h12345678 -> data_o[0]=0, valid_o[0]=0, wr_count_o unchanged, no ack. Repeat with zero_entry=0 -> data_o[0]=32'h12345678.
- Priority:
  - clear_i=1 with we_i=1, sel_i=3 after entries 3 and 7 were filled -> all entries 0, valid_o=0, count 0;
  - rst_i=1 with clear_i=1 and a write -> same all-zero result.
- Back-to-back and sweep:
  - write 32'h1 then 32'h2 to sel_i=9 on consecutive cycles -> data_o[9]=32'h2, count +2, wr_ack_o high for 2 cycles;
  - write index i to each of entries 1..31 -> data_o[i]=i, valid_o=32'hFFFFFFFE.
- Saturation: force 65537 accepted writes -> wr_count_o=16'hFFFF, and data_o still tracks the last write.
